// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
//   Write-back initiator for the 64x32 register file. Results from the
//   execute/memory stages are buffered in a circular FIFO and drained one
//   write per cycle onto the register file write port (wrt, rd, datain).
//   Producers see backpressure through in_ready when the queue is full.
//
// Optional feature:
//   REGFILE_WB_FORWARD_EN  adds a combinational forwarding lookup
//                          (lookup_addr, lookup_hit, lookup_data) over the
//                          queued entries and the output stage.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  producer handshake
//   in_rd, in_data      destination register and value of a result
//   stall               hold drain; no write is issued after this edge
//   wrt, rd, datain     registered register file write port
//   count, empty, full  queue occupancy, derived from the registered count
//   lookup_addr/_hit/_data  forwarding query (REGFILE_WB_FORWARD_EN only)
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_rd,
    input  logic [DW-1:0]            in_data,
    input  logic                     stall,
`ifdef REGFILE_WB_FORWARD_EN
    input  logic [AW-1:0]            lookup_addr,
    output logic                     lookup_hit,
    output logic [DW-1:0]            lookup_data,
`endif
    output logic                     wrt,
    output logic [AW-1:0]            rd,
    output logic [DW-1:0]            datain,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] q_rd   [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    // Full blocks acceptance even when a pop happens at the same edge.
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && !stall;

    // Storage carries no reset; entries outside [head, head+count) are
    // never observed. push is already suppressed during reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[tail]   <= in_rd;
            q_data[tail] <= in_data;
        end
    end

    // DEPTH is a power of two, so the PW-bit pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            wrt     <= 1'b0;
            rd      <= '0;
            datain  <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            wrt <= pop;
            if (pop) begin
                rd     <= q_rd[head];
                datain <= q_data[head];
                head   <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef REGFILE_WB_FORWARD_EN
    logic [PW-1:0] fwd_slot;

    // Output stage is the lowest-priority candidate; queued entries are
    // scanned oldest to youngest so the youngest match wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        fwd_slot    = head;
        if (wrt && (rd == lookup_addr)) begin
            lookup_hit  = 1'b1;
            lookup_data = datain;
        end
        for (int i = 0; i < DEPTH; i++) begin
            fwd_slot = head + PW'(i);
            if ((CW'(i) < count_q) && (q_rd[fwd_slot] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = q_data[fwd_slot];
            end
        end
    end
`endif

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-back initiator for the 64x32 register file; drives its write port (wrt, rd, datain).
- Buffers (destination, data) results from execute/memory stages in a small circular FIFO.
- Drains one write per cycle to the register file and applies backpressure to producers when full.
- Optionally provides a forwarding lookup, so readers can see values still queued or in flight to the register file.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
AW, 6, register address width (64 registers)
DW, 32, data width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  producer has a result
in_ready  output  1  queue can accept this cycle
in_rd  input  AW  destination register of result
in_data  input  DW  result value
stall  input  1  hold drain (no write issued this cycle)
wrt  output  1  register file write enable
rd  output  AW  register file write address
datain  output  DW  register file write data
count  output  clog2(DEPTH)+1  entries currently queued
empty  output  1  count == 0
full  output  1  count == DEPTH
lookup_addr  input  AW  forwarding query address (FORWARD_EN only)
lookup_hit  output  1  query matches pending write (FORWARD_EN only)
lookup_data  output  DW  forwarded value (FORWARD_EN only)

Behaviour:
- Reset values (edge with rst=1):
  - count=0; head and tail pointers =0.
  - wrt=0, rd=0, datain=0.
  - All queued entries are discarded.
  - Reset mid-operation issues no further writes for discarded entries.
- in_ready = !full && !rst (combinational).
- Push occurs when in_valid && in_ready at a rising edge:
  - entry written at tail; tail = (tail+1) mod DEPTH.
- Pop occurs when !empty && !stall at a rising edge:
  - head entry is copied to the registered outputs (wrt=1, rd=entry.rd, datain=entry.data).
  - head = (head+1) mod DEPTH.
- No pop at an edge: wrt=0 next cycle; rd and datain hold their last values.
- Latency: an entry accepted at edge k into an empty, unstalled queue shows wrt=1 between edges k+1 and k+2; the register file commits it at edge k+2.
- Order: strictly FIFO. Two writes to the same rd commit in acceptance order.
- Push and pop at the same edge: count unchanged; both take effect.
- Full: in_ready=0, even if a pop happens at the same edge. There is no same-cycle pass-through.
- Empty with in_valid=1: the entry is accepted; it is not written to the register file in the same cycle.
- stall=1: queue contents frozen except for pushes; wrt=0 the following cycle.
- Pointer wrap: increments past DEPTH-1 return to 0. count never exceeds DEPTH and never underflows.
- count, empty and full are derived from registered count and update on the edge after push/pop.

Optional Feature:
- Macro: REGFILE_WB_FORWARD_EN.
- Defined: lookup_addr, lookup_hit and lookup_data exist; lookup is combinational.
  - Hit candidates: valid queued entries with rd == lookup_addr, plus the output stage when wrt=1 and rd == lookup_addr.
  - Priority: youngest queued match first, then the output stage.
  - lookup_hit=0 → lookup_data=0.
  - Entries accepted in the current cycle (not yet pushed) are not candidates.
- Undefined: the three lookup ports and all match logic are absent; all other behaviour is identical.

Test Plan:
- Reset then single push (in_rd=5, in_data=32'hDEADBEEF) at edge 1 → wrt=1, rd=5, datain=32'hDEADBEEF during cycle after edge 2 only; count 1 then 0.
- Stall held high, push 4 entries (rd=1..4, data=10..13) → full=1, in_ready=0, wrt=0; a 5th in_valid is not accepted. Release stall → four consecutive wrt pulses in order rd=1,2,3,4, then empty=1.
- Continuous push and pop each cycle for 10 cycles with count=2 → count stays 2; pointers wrap past DEPTH-1 without loss or reordering.
- Two writes to rd=7 (data 1 then 2) → committed in order; register 7 finally reads 2.
- Assert rst with 3 entries queued → next cycle count=0, wrt=0, rd=0, datain=0; no writes issued afterwards.
- REGFILE_WB_FORWARD_EN: queue rd=9/data=0xA then rd=9/data=0xB, lookup_addr=9 → lookup_hit=1, lookup_data=0xB. After both drain and wrt=0 → lookup_hit=0, lookup_data=0.
